dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Decoded-instruction FIFO directly downstream of the fetch/decode stage (InstQ).
- Buffers decoded fields (opcode, rs, rt, rd, shamt, immediate, address, pc) so a dispatch stall into the reservation stations / ROB does not lose instructions.
- Provides a valid/ready handshake to dispatch.
- Handles branch-mispredict flush and halt blocking.

Parameters:
- DEPTH, 8, number of entries (power of two, ≥2).
- PTR_W, 3, log2(DEPTH).
- HLT_OPCODE, 12'hFC0, packed 12-bit opcode of hlt ({6'h3F, 6'd0}).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (mispredict/exception), synchronous.
- in_valid  in  1  decode presents a valid instruction (VALID_Inst).
- in_opcode  in  12  packed opcode.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_immediate  in  16  immediate.
- in_address  in  26  jump target field.
- in_pc  in  32  instruction PC.
- in_ready  out  1  queue can accept this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  dispatch accepts head this cycle.
- out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address, out_pc  out  same widths as inputs  head entry fields.
- count  out  PTR_W+1  current occupancy.
- halted  out  1  hlt has been enqueued.

Behaviour:
- Reset (rst=0, async):
  - head=tail=0, count=0, halted=0.
  - out_valid=0, all out_* fields=0, in_ready=1.
  - Storage contents need not be cleared.
  - Reset mid-operation drops all entries immediately.
- Entry packing: 106 bits = {pc, address, immediate, shamt, rd, rt, rs, opcode}.
- Push: posedge where in_valid & in_ready. Writes mem[tail], tail=tail+1 mod DEPTH.
- Pop: posedge where out_valid & out_ready. head=head+1 mod DEPTH.
- in_ready = (count != DEPTH) & ~halted. No combinational path from out_ready to in_ready, so push while full is refused even if a pop happens the same cycle.
- out_valid = (count != 0). out_* = mem[head], driven combinationally from the registered array and head pointer.
- Latency: an entry pushed at edge N is visible on out_* after edge N, so it is poppable at edge N+1 (1 cycle).
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance, count unchanged.
- Pointer wrap: DEPTH-1 → 0. count disambiguates full (DEPTH) from empty (0).
- Halt:
  - Pushing an entry whose in_opcode == HLT_OPCODE sets halted=1 at that edge.
  - While halted, in_ready=0. Queued entries, including the hlt itself, still drain normally.
- flush (synchronous, highest priority):
  - At the edge: head=tail=0, count=0, halted=0.
  - Any same-cycle push or pop is ignored.
  - out_valid=0 after the edge.
- Inputs come from a negedge-updated stage; they are sampled at posedge only (half-cycle path, no extra register).
- in_valid while in_ready=0: instruction not taken. Upstream PC generation must hold/replay it.

Optional Feature:
- Macro: DISPATCHQ_BYPASS_EN.
- Defined:
  - When count==0 & in_valid & ~halted & ~flush, out_valid=1 and out_* = in_* combinationally in the same cycle.
  - If out_ready also =1, the entry is consumed without being written; pointers and count are unchanged, halted still sets on hlt.
  - If out_ready=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum latency 1 cycle as above.

Decomposition:
- Shared package (dispatch_pkg):
  - field widths (OPC_W=12, REG_W=5, IMM_W=16, ADDR_W=26, PC_W=32, ENTRY_W=106);
  - HLT_OPCODE;
  - entry pack/unpack functions.
- One natural sub-module: dq_storage, a DEPTH×ENTRY_W register array with a write port and a combinational read port. Pointer/count/halt control stays in dispatch_queue.

Test Plan:
- Reset with rst=0 for 2 cycles, then release → count=0, out_valid=0, in_ready=1, halted=0, out_pc=0.
- Push 3 instrs (pc=0,1,2; opcode 12'h800 addi) with out_ready=0 → count=3, out_pc=0. Then out_ready=1 for 3 cycles → out_pc sequence 0,1,2, then out_valid=0.
- Push 8 with out_ready=0 → count=8, in_ready=0. A 9th in_valid is not taken. Pop one → in_ready=1. Push pc=8 → it pops after pc=1..7 (wrap check).
- Steady state: push and pop every cycle with count=4 → count stays 4 for 20 cycles and out_pc increments by 1 each cycle.
- Push pc=0..2 with pc=2 opcode 12'hFC0 → halted=1, in_ready=0. Drain 3 → out_opcode of the last entry = 12'hFC0, count=0, in_ready stays 0.
- With count=5, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, halted=0, pushed instruction dropped. Repeat with rst pulsed low mid-stream → same result asynchronously.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared field widths, hlt encoding and entry packing for the dispatch queue.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dispatch_pkg;

    localparam int OPC_W   = 12;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int ADDR_W  = 26;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = PC_W + ADDR_W + IMM_W + 4 * REG_W + OPC_W;  // 106

    // hlt = {6'h3F, 6'd0} in the packed opcode form used by decode
    localparam logic [OPC_W-1:0] HLT_OPCODE = 12'hFC0;

    // Declaration order gives the storage layout
    // {pc, address, immediate, shamt, rd, rt, rs, opcode}, pc in the MSBs.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [ADDR_W-1:0] address;
        logic [IMM_W-1:0]  immediate;
        logic [REG_W-1:0]  shamt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rs;
        logic [OPC_W-1:0]  opcode;
    } entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input entry_t e);
        return e;
    endfunction

    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] v);
        return entry_t'(v);
    endfunction

endpackage

// File: rtl/dq_storage.sv
// DEPTH x WIDTH register array, one write port, one combinational read port.
// Latency: write visible on the read port after the writing edge.
// Backpressure: none; the caller gates wr_en.
// Ports: clk, wr_en/wr_ptr/wr_dat (write), rd_ptr -> rd_dat (async read).
module dq_storage
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] rd_dat
);

    // Contents are never reset: the control logic masks empty slots.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/dispatch_queue.sv
// Decoded-instruction FIFO between decode and dispatch, with flush and hlt blocking.
// Latency: 1 cycle push-to-pop (0 when empty with DISPATCHQ_BYPASS_EN defined).
// Backpressure: in_ready low when full or after hlt is taken; in_ready never depends on out_ready.
// Ports: clk, rst (async active-low), flush; in_valid/in_ready + in_* fields;
//        out_valid/out_ready + out_* fields; count (occupancy), halted.
// Optional macro: DISPATCHQ_BYPASS_EN enables empty-queue combinational bypass.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int              DEPTH      = 8,
    parameter int              PTR_W      = 3,
    parameter logic [OPC_W-1:0] HLT_OPCODE = dispatch_pkg::HLT_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_shamt,
    input  logic [IMM_W-1:0]  in_immediate,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_shamt,
    output logic [IMM_W-1:0]  out_immediate,
    output logic [ADDR_W-1:0] out_address,
    output logic [PC_W-1:0]   out_pc,

    output logic [PTR_W:0]    count,
    output logic              halted
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    entry_t           in_ent;
    entry_t           head_ent;
    entry_t           out_ent;
    logic [ENTRY_W-1:0] rd_dat;

    logic             bypass_vld;   // empty queue forwarding the input this cycle
    logic             take;         // instruction accepted from decode
    logic             push;         // accepted instruction actually written
    logic             pop;          // stored head entry consumed

    assign in_ent = '{
        pc:        in_pc,
        address:   in_address,
        immediate: in_immediate,
        shamt:     in_shamt,
        rd:        in_rd,
        rt:        in_rt,
        rs:        in_rs,
        opcode:    in_opcode
    };

    // Registered-only: a same-cycle pop never frees a slot for a same-cycle push.
    assign in_ready = (count != FULL_CNT) & ~halted;

`ifdef DISPATCHQ_BYPASS_EN
    assign bypass_vld = (count == '0) & in_valid & ~halted & ~flush;
`else
    assign bypass_vld = 1'b0;
`endif

    assign out_valid = (count != '0) | bypass_vld;

    // flush wins over everything at the edge.
    assign take = in_valid & in_ready & ~flush;
    // A bypassed entry that dispatch accepts immediately never touches storage.
    assign push = take & ~(bypass_vld & out_ready);
    assign pop  = (count != '0) & out_ready & ~flush;

    dq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk    (clk),
        .wr_en  (push),
        .wr_ptr (tail),
        .wr_dat (pack_entry(in_ent)),
        .rd_ptr (head),
        .rd_dat (rd_dat)
    );

    assign head_ent = unpack_entry(rd_dat);

    // Output fields read zero whenever nothing is presented, so stale
    // storage contents never leak onto the dispatch bus.
    always_comb begin
        out_ent = '0;
        if (bypass_vld) begin
            out_ent = in_ent;
        end else if (count != '0) begin
            out_ent = head_ent;
        end
    end

    assign out_opcode    = out_ent.opcode;
    assign out_rs        = out_ent.rs;
    assign out_rt        = out_ent.rt;
    assign out_rd        = out_ent.rd;
    assign out_shamt     = out_ent.shamt;
    assign out_immediate = out_ent.immediate;
    assign out_address   = out_ent.address;
    assign out_pc        = out_ent.pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // hlt blocks further intake even when it is bypassed straight out.
            if (take && (in_opcode == HLT_OPCODE)) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
    import dispatch_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [OPC_W-1:0]  in_opcode = '0;
    logic [REG_W-1:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [IMM_W-1:0]  in_immediate = '0;
    logic [ADDR_W-1:0] in_address = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OPC_W-1:0]  out_opcode;
    logic [REG_W-1:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [IMM_W-1:0]  out_immediate;
    logic [ADDR_W-1:0] out_address;
    logic [PC_W-1:0]   out_pc;
    logic [PTR_W:0]    count;
    logic              halted;

    dispatch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .HLT_OPCODE(12'hFC0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_immediate(in_immediate),
        .in_address(in_address), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_immediate(out_immediate), .out_address(out_address), .out_pc(out_pc),
        .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    entry_t sb[$];          // expected dispatch order
    int     m_cnt = 0;      // reference occupancy
    bit     m_halted = 1'b0;
    bit     exp_rdy = 1'b1;
    bit     exp_vld = 1'b0;
    bit     mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, update the reference model at posedge.
    task automatic step(input bit v, input logic [11:0] opc, input logic [31:0] pc,
                        input bit ordy, input bit fl);
        entry_t e;
        bit     push, pop, byp;
        @(negedge clk);
        in_valid     = v;
        in_opcode    = opc;
        in_pc        = pc;
        in_rs        = REG_W'($urandom);
        in_rt        = REG_W'($urandom);
        in_rd        = REG_W'($urandom);
        in_shamt     = REG_W'($urandom);
        in_immediate = IMM_W'($urandom);
        in_address   = ADDR_W'($urandom);
        out_ready    = ordy;
        flush        = fl;
        e = '{pc: in_pc, address: in_address, immediate: in_immediate, shamt: in_shamt,
              rd: in_rd, rt: in_rt, rs: in_rs, opcode: in_opcode};
        exp_rdy = (m_cnt != DEPTH) && !m_halted;
        byp = 1'b0;
`ifdef DISPATCHQ_BYPASS_EN
        byp = (m_cnt == 0) && v && !m_halted && !fl;
`endif
        exp_vld = (m_cnt != 0) || byp;
        push = v && exp_rdy && !fl;
        if (push) sb.push_back(e);
        @(posedge clk);
        if (fl) begin
            m_cnt = 0;
            m_halted = 1'b0;
            sb.delete();
        end else begin
            pop = exp_vld && ordy;
            if (push && opc == 12'hFC0) m_halted = 1'b1;
            m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 12'h000, 32'h0, ordy, 1'b0);
    endtask

    // Monitor: sample well after the negedge drive, well before the posedge.
    always @(negedge clk) begin
        entry_t got, e;
        #2;
        if (mon_en && rst) begin
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(exp_vld));
            chk("count", 64'(count), 64'(m_cnt));
            chk("halted", 64'(halted), 64'(m_halted));
            if (!out_valid) chk("out_pc_idle", 64'(out_pc), 64'h0);
            if (out_valid && out_ready && !flush) begin
                got = '{pc: out_pc, address: out_address, immediate: out_immediate,
                        shamt: out_shamt, rd: out_rd, rt: out_rt, rs: out_rs,
                        opcode: out_opcode};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got pc=%0h with nothing expected (t=%0t)",
                             out_pc, $time);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL entry: got pc=%0h opc=%0h imm=%0h expected pc=%0h opc=%0h imm=%0h (t=%0t)",
                                 got.pc, got.opcode, got.immediate, e.pc, e.opcode, e.immediate, $time);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        // Power-on reset for two cycles, released away from the active edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Three addi, held, then drained in order.
        for (int i = 0; i < 3; i++) step(1'b1, 12'h800, 32'(i), 1'b0, 1'b0);
        repeat (4) idle(1'b1);

        // Fill to DEPTH, refused ninth, pop one, push pc=8 into the wrapped slot.
        for (int i = 0; i < 8; i++) step(1'b1, 12'h800, 32'(i), 1'b0, 1'b0);
        step(1'b1, 12'h800, 32'd99, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 12'h800, 32'd8, 1'b0, 1'b0);
        repeat (9) idle(1'b1);

        // Steady state at occupancy 4.
        for (int i = 0; i < 4; i++) step(1'b1, 12'h800, 32'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 12'h800, 32'(104 + i), 1'b1, 1'b0);
        repeat (5) idle(1'b1);

        // hlt blocks intake but drains itself.
        step(1'b1, 12'h800, 32'd0, 1'b0, 1'b0);
        step(1'b1, 12'h800, 32'd1, 1'b0, 1'b0);
        step(1'b1, 12'hFC0, 32'd2, 1'b0, 1'b0);
        step(1'b1, 12'h800, 32'd3, 1'b0, 1'b0);
        repeat (4) idle(1'b1);
        step(1'b1, 12'h800, 32'd4, 1'b1, 1'b0);
        step(1'b0, 12'h000, 32'd0, 1'b0, 1'b1);
        idle(1'b0);

        // Flush at count=5 with a concurrent push and pop.
        for (int i = 0; i < 5; i++) step(1'b1, 12'h800, 32'(200 + i), 1'b0, 1'b0);
        step(1'b1, 12'h800, 32'd250, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) step(1'b1, 12'h800, 32'(300 + i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_pc", 64'(out_pc), 64'h0);
        m_cnt = 0;
        m_halted = 1'b0;
        sb.delete();
        exp_rdy = 1'b1;
        exp_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1'b0);

        // Random traffic with occasional hlt and flush.
        for (int i = 0; i < 400; i++) begin
            logic [11:0] opc;
            opc = ($urandom_range(0, 24) == 0) ? 12'hFC0 : 12'($urandom);
            step($urandom_range(0, 3) != 0, opc, 32'(1000 + i),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        repeat (10) idle(1'b1);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
